// File: rtl/timer_bank.sv
// Bank of NUM_CH memory-mapped down-counting timers sharing one prescaler,
// with a fixed-priority combined interrupt and a one-cycle acknowledge.
module timer_bank #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 1,
  parameter int ADDR_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_timer_int,
  output logic [2:0]        o_int_id,
  input  logic              i_timer_int_ack
);

  localparam int CHW = ADDR_W - 4;
  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]    r_presc;
  logic             w_tick;

  logic [CNT_W-1:0] r_load  [NUM_CH];
  logic [CNT_W-1:0] r_count [NUM_CH];
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_per;
  logic [NUM_CH-1:0] r_irq;
  logic [NUM_CH-1:0] r_pend;

  logic [CHW-1:0]   w_ch;
  logic [1:0]       w_sel;
  logic             w_valid;
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_run;
  logic [NUM_CH-1:0] w_exp;
  logic [NUM_CH-1:0] w_ack;
  logic             w_unused;

  assign w_ch     = i_addr[ADDR_W-1:4];
  assign w_sel    = i_addr[3:2];
  assign w_valid  = ({1'b0, w_ch} < (CHW+1)'(NUM_CH));
  assign w_tick   = (r_presc == PW'(PRESCALE - 1));
  assign w_unused = ^{i_addr[1:0], i_wdata};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      r_presc <= '0;
    else if (w_tick)
      r_presc <= '0;
    else
      r_presc <= r_presc + PW'(1);
  end

  // Lowest pending-and-enabled channel wins, so scan from the top down.
  always_comb begin
    o_timer_int = 1'b0;
    o_int_id    = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pend[i] && r_irq[i]) begin
        o_timer_int = 1'b1;
        o_int_id    = 3'(i);
      end
    end
  end

  // A CTRL write clearing en freezes the counter in that same cycle.
  always_comb begin
    w_hit = '0;
    w_run = '0;
    w_exp = '0;
    w_ack = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_hit[i] = i_we && w_valid && (w_ch == CHW'(i));
      w_run[i] = r_en[i] && w_tick && !(w_hit[i] && (w_sel == 2'd0) && !i_wdata[0]);
      w_exp[i] = w_run[i] && (r_count[i] == '0);
      w_ack[i] = i_timer_int_ack && o_timer_int && (o_int_id == 3'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_load[i]  <= '0;
        r_count[i] <= '0;
      end
      r_en   <= '0;
      r_per  <= '0;
      r_irq  <= '0;
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_exp[i])
          r_pend[i] <= 1'b1;
        else if (w_ack[i] || (w_hit[i] && (w_sel == 2'd3) && i_wdata[0]))
          r_pend[i] <= 1'b0;

        // Software loads take priority over the tick for COUNT.
        if (w_hit[i] && (w_sel == 2'd1)) begin
          r_load[i]  <= i_wdata[CNT_W-1:0];
          r_count[i] <= i_wdata[CNT_W-1:0];
        end else if (w_hit[i] && (w_sel == 2'd0) && i_wdata[0] && !r_en[i]) begin
          r_count[i] <= r_load[i];
        end else if (w_run[i]) begin
          if (r_count[i] != '0)
            r_count[i] <= r_count[i] - CNT_W'(1);
          else if (r_per[i])
            r_count[i] <= r_load[i];
        end

        if (w_hit[i] && (w_sel == 2'd0)) begin
          r_en[i]  <= i_wdata[0];
          r_per[i] <= i_wdata[1];
          r_irq[i] <= i_wdata[2];
        end else if (w_exp[i] && !r_per[i]) begin
          r_en[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_valid && (w_ch == CHW'(i))) begin
        case (w_sel)
          2'd0:    o_rdata[2:0]       = {r_irq[i], r_per[i], r_en[i]};
          2'd1:    o_rdata[CNT_W-1:0] = r_load[i];
          2'd2:    o_rdata[CNT_W-1:0] = r_count[i];
          default: o_rdata[0]         = r_pend[i];
        endcase
      end
    end
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised successor to the single fixed-period board timer.
- Provides NUM_CH independent down-counting timers. Each channel supports one-shot or periodic mode, has its own interrupt enable, and shares one prescaler.
- Sits on the MIO bus as a memory-mapped slave and drives the CPU timer interrupt/acknowledge pair.
- One combined interrupt line is fixed-priority: lowest channel index wins.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
CNT_W, 32, counter/load register width (8..32)
PRESCALE, 1, clk cycles per timer tick (>=1)
ADDR_W, 8, byte-address width of the register window (>= 4+clog2(NUM_CH))

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
we  in  1  register write strobe (one cycle = one write)
addr  in  ADDR_W  byte address; [3:2] register select, [ADDR_W-1:4] channel index
wdata  in  32  write data
rdata  out  32  combinational read data for addr
timer_int  out  1  OR over channels of (pending & irq_en)
int_id  out  3  index of lowest-numbered channel with pending & irq_en; 0 when timer_int=0
timer_int_ack  in  1  one-cycle acknowledge from CPU; clears pending of channel int_id

Behaviour:
- Reset: every LOAD, COUNT, CTRL and pending bit is 0. The prescaler is 0. timer_int=0, int_id=0, rdata reflects zeroed registers. Reset is asynchronous and overrides everything mid-operation, including a counter in flight or a pending interrupt.
- Register map per channel, base = ch*16:
  - +0 CTRL (rw): bit0 en, bit1 periodic, bit2 irq_en; other bits read 0.
  - +4 LOAD (rw): CNT_W bits, zero-extended on read.
  - +8 COUNT (ro): writes are ignored.
  - +C STATUS: bit0 pending. Writing 1 clears pending; writing 0 has no effect.
- A channel index >= NUM_CH reads 0, and writes to it are ignored.
- Prescaler:
  - Free-running 0..PRESCALE-1. tick=1 in the cycle the prescaler equals PRESCALE-1, then it wraps to 0.
  - With PRESCALE=1, tick=1 every cycle.
- Counting, evaluated per channel in each cycle where tick=1 and en=1:
  - COUNT != 0: COUNT <= COUNT-1.
  - COUNT == 0 (expiry): pending <= 1.
    - Periodic: COUNT <= LOAD.
    - One-shot: en <= 0 and COUNT stays 0.
  - Period is therefore (LOAD+1) ticks. LOAD=0 in periodic mode expires every tick.
- Software loads:
  - A write to LOAD also sets COUNT <= wdata in the same edge. This takes priority over a tick decrement that cycle.
  - A CTRL write that changes en from 0 to 1 sets COUNT <= LOAD.
  - A CTRL write with en=0 freezes COUNT. Pending is retained.
- Interrupt output:
  - timer_int and int_id are combinational from the registered pending and irq_en bits. Latency from the expiry tick edge to timer_int=1 is 0 cycles after that edge.
  - A pending bit with irq_en=0 is still visible in STATUS but does not assert timer_int.
- Acknowledge:
  - timer_int_ack=1 clears pending of channel int_id at the next edge.
  - An ack while timer_int=0 is ignored.
  - Only one channel is cleared per ack. Remaining pendings keep timer_int high, and int_id moves to the next channel.
- Simultaneous events on the same channel in the same cycle:
  - Expiry with STATUS W1C or with ack: set wins, pending stays 1.
  - LOAD write with expiry: LOAD write wins for COUNT, and pending is still set.
- Arithmetic is unsigned modulo 2^CNT_W. Upper wdata bits beyond CNT_W are dropped.

Test Plan:
- Reset, then read all registers of ch0..NUM_CH-1 → all 0, timer_int=0. Assert rstn=0 mid-count → COUNT/pending/timer_int=0 immediately, no clk edge needed.
- PRESCALE=1, ch0 LOAD=3, CTRL=0x7 (en, periodic, irq_en) → timer_int rises 4 cycles after the enabling edge, then every 4 cycles; COUNT sequence 3,2,1,0,3.
- ch1 one-shot LOAD=2, CTRL=0x5 → single expiry after 3 ticks, CTRL.en reads 0, COUNT stays 0, no second pending.
- ch0 and ch2 expire in the same cycle with irq_en set → int_id=0. First ack → int_id=2, timer_int=1. Second ack → timer_int=0.
- Expiry and STATUS write 1 in the same cycle on ch0 → pending reads 1. The next W1C clears it.
- PRESCALE=4 build, LOAD=1 → expiry after 8 clk cycles. Write to channel NUM_CH → ignored, reads 0.
